// File: rtl/serial_pkg.sv
// Shared line-level definitions for the serial transmit/capture pair.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load shift register presenting the next bit to transmit on head_o.
module piso_shift_reg
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             head_o
);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] shifted;

    // The head bit always sits at the end the stream is read from.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {sr_q[WIDTH-2:0], 1'b0};
            assign head_o  = sr_q[WIDTH-1];
        end else begin : g_lsb
            assign shifted = {1'b0, sr_q[WIDTH-1:1]};
            assign head_o  = sr_q[0];
        end
    endgenerate

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = d_i;
        end else if (shift_i) begin
            sr_d = shifted;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/piso_frame_serializer.sv
// Framed serial transmitter: start bit, WIDTH data bits, stop bit on a registered line.
module piso_frame_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    input  logic             D_valid,
    output logic             D_ready,
    output logic             Q,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_q, busy_q, done_q;
    logic             accept, shift_en, head;

    assign D_ready  = (state_q == IDLE || state_q == STOP) && !reset;
    assign accept   = D_valid && D_ready;
    // The head is consumed on the edge that puts it on the line, so shifting
    // starts at the START->DATA edge and stops once the last bit is launched.
    assign shift_en = (state_q == START) || (state_q == DATA && cnt_q != LAST);

    piso_shift_reg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_sr (
        .clk_i  (CLK),
        .rst_i  (reset),
        .load_i (accept),
        .shift_i(shift_en),
        .d_i    (D),
        .head_o (head)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q <= START;
                        q_q     <= START_BIT;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    state_q <= DATA;
                    cnt_q   <= '0;
                    q_q     <= head;
                end
                DATA: begin
                    if (cnt_q == LAST) begin
                        state_q <= STOP;
                        q_q     <= STOP_BIT;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        q_q   <= head;
                    end
                end
                STOP: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q <= START;
                        q_q     <= START_BIT;
                    end else begin
                        state_q <= IDLE;
                        q_q     <= LINE_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    q_q     <= LINE_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Q    = q_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Bench for piso_frame_serializer: MSB-first and LSB-first instances against a frame-queue model.
module tb_piso_frame_serializer;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         reset;
    logic [W-1:0] D;
    logic         D_valid;
    logic         rdy0, rdy1, q0, q1, busy0, busy1, done0, done1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    piso_frame_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .CLK(CLK), .reset(reset), .D(D), .D_valid(D_valid), .D_ready(rdy0),
        .Q(q0), .busy(busy0), .done(done0));

    piso_frame_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .CLK(CLK), .reset(reset), .D(D), .D_valid(D_valid), .D_ready(rdy1),
        .Q(q1), .busy(busy1), .done(done1));

    // One entry per line cycle; both instances share timing, only bit order differs.
    typedef struct packed {
        logic q_msb;
        logic q_lsb;
        logic busy;
        logic done;
    } cyc_t;

    localparam cyc_t IDLE_CYC = '{q_msb: 1'b1, q_lsb: 1'b1, busy: 1'b0, done: 1'b0};

    cyc_t cur = IDLE_CYC;
    cyc_t fq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        return ((!cur.busy) || cur.done) && !reset;
    endfunction

    task automatic model_step();
        cyc_t c;
        if (reset) begin
            fq.delete();
            cur = IDLE_CYC;
        end else if (D_valid && model_ready()) begin
            fq.delete();
            c = '{q_msb: 1'b0, q_lsb: 1'b0, busy: 1'b1, done: 1'b0};
            fq.push_back(c);
            for (int i = 0; i < W; i++) begin
                c = '{q_msb: D[W-1-i], q_lsb: D[i], busy: 1'b1, done: 1'b0};
                fq.push_back(c);
            end
            c = '{q_msb: 1'b1, q_lsb: 1'b1, busy: 1'b1, done: 1'b1};
            fq.push_back(c);
            cur = fq.pop_front();
        end else if (fq.size() > 0) begin
            cur = fq.pop_front();
        end else begin
            cur = IDLE_CYC;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic at_sample();
        @(negedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("q_msb", q0, cur.q_msb);
            check("q_lsb", q1, cur.q_lsb);
            check("busy_msb", busy0, cur.busy);
            check("busy_lsb", busy1, cur.busy);
            check("done_msb", done0, cur.done);
            check("done_lsb", done1, cur.done);
            check("ready_msb", rdy0, model_ready());
            check("ready_lsb", rdy1, model_ready());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  seq_a, seq_b, seq_r;
        logic [19:0] seq_bb;
        int          ndone, first_done, second_done;

        reset = 1'b1; D_valid = 1'b0; D = 'x;
        for (int i = 0; i < 3; i++) tick();
        chk_en = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        at_sample();
        check("idle_q", q0, 1'b1);
        check("idle_busy", busy0, 1'b0);
        check("idle_ready", rdy0, 1'b1);

        // 8'hA5, single-cycle valid
        D = 8'hA5; D_valid = 1'b1;
        tick();
        D_valid = 1'b0; D = 'x;
        seq_a = '0; seq_b = '0;
        for (int i = 0; i < 10; i++) begin
            at_sample();
            seq_a[9-i] = q0;
            seq_b[9-i] = done0;
            tick();
        end
        check("a5_msb_seq", 32'(seq_a), 32'(10'b0101001011));
        check("a5_done_seq", 32'(seq_b), 32'(10'b0000000001));
        at_sample();
        check("a5_back_idle", q0, 1'b1);

        // 8'h01 on the LSB-first instance
        for (int i = 0; i < 3; i++) tick();
        D = 8'h01; D_valid = 1'b1;
        tick();
        D_valid = 1'b0; D = 'x;
        for (int i = 0; i < 10; i++) begin
            at_sample();
            seq_a[9-i] = q1;
            seq_r[9-i] = rdy1;
            tick();
        end
        check("lsb01_seq", 32'(seq_a), 32'(10'b0100000001));
        check("lsb01_ready", 32'(seq_r), 32'(10'b0000000001));

        // Back-to-back: FF then 00 offered in the stop cycle
        for (int i = 0; i < 2; i++) tick();
        D = 8'hFF; D_valid = 1'b1;
        tick();
        ndone = 0; first_done = -1; second_done = -1;
        for (int i = 0; i < 22; i++) begin
            at_sample();
            if (i < 20) seq_bb[19-i] = q0;
            if (done0) begin
                ndone++;
                if (first_done < 0) first_done = i; else second_done = i;
            end
            D       = (i == 9) ? 8'h00 : 8'hFF;
            D_valid = (i <= 9);
            tick();
        end
        D_valid = 1'b0; D = 'x;
        check("b2b_seq", 32'(seq_bb), 32'(20'b01111111110000000001));
        check("b2b_done_count", 32'(ndone), 32'd2);
        check("b2b_done_gap", 32'(second_done - first_done), 32'd10);

        // Ignored word during the 4th data bit of a C3 frame
        for (int i = 0; i < 2; i++) tick();
        D = 8'hC3; D_valid = 1'b1;
        tick();
        D_valid = 1'b0; D = 'x;
        for (int i = 0; i < 10; i++) begin
            at_sample();
            seq_a[9-i] = q0;
            if (i == 4) begin D = 8'h3C; D_valid = 1'b1; end
            else begin D = 'x; D_valid = 1'b0; end
            tick();
        end
        D_valid = 1'b0; D = 'x;
        check("ignore_seq", 32'(seq_a), 32'(10'b0110000111));
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            at_sample();
            if (q0 !== 1'b1) ndone++;
            tick();
        end
        check("ignore_not_sent", 32'(ndone), 32'd0);

        // Reset during the 5th data bit
        D = 8'h5A; D_valid = 1'b1;
        tick();
        D_valid = 1'b0; D = 'x;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        at_sample();
        check("rst_mid_q", q0, 1'b1);
        check("rst_mid_busy", busy0, 1'b0);
        check("rst_mid_done", done0, 1'b0);
        check("rst_mid_ready", rdy0, 1'b1);
        for (int i = 0; i < 12; i++) tick();

        // Randomized traffic with occasional reset and valid/reset collisions
        for (int i = 0; i < 1500; i++) begin
            D       = W'($urandom);
            D_valid = ($urandom_range(0, 9) < 4);
            reset   = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0; D_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
